// File: rtl/program_sequencer.sv
// program_sequencer
// Feeds a small CPU one opcode per clock from a 16 x 8 program memory.
// Jump-class opcodes (8x, 9x, Dx) insert one bubble cycle while the CPU
// resolves the target on OpAddOut; Fx or the CPU halt flag end the run.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   load_en      program memory write strobe (honoured only in IDLE/DONE)
//   load_addr    program memory write address
//   load_data    program memory write data
//   start        begin execution from address 0
//   halt         CPU halt flag
//   ZF           CPU zero flag (decides 8x branches)
//   OpAddOut     CPU jump target, valid during STALL
//   opcode       registered opcode presented to the CPU
//   pc           address of the next opcode to fetch
//   running      high in RUN or STALL
//   done         high in DONE
//   fetch_count  program opcodes issued since start, saturating at 255
//
// state | meaning
// IDLE  | after reset, waiting for start, memory writable
// RUN   | presenting program opcodes, decoding the current one each edge
// STALL | bubble after a jump-class opcode, target resolved this cycle
// DONE  | halted, memory writable, start restarts from address 0
module program_sequencer #(
   parameter logic [7:0] BUBBLE = 8'h00
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load_en,
   input  logic [3:0] load_addr,
   input  logic [7:0] load_data,
   input  logic       start,
   input  logic       halt,
   input  logic       ZF,
   input  logic [3:0] OpAddOut,
   output logic [7:0] opcode,
   output logic [3:0] pc,
   output logic       running,
   output logic       done,
   output logic [7:0] fetch_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_STALL = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [7:0] mem [16];
   logic [7:0] opcode_n;
   logic [3:0] pc_n;
   logic [7:0] count_n;
   logic [3:0] kind;
   logic [3:0] kind_n;
   logic       fetch;
   logic       restart;
   logic [3:0] fetch_addr;
   logic       jump_taken;
   logic       wr_en;

   // 8x is a conditional branch on ZF clear; 9x and Dx always jump.
   assign jump_taken = (kind == 4'h9) || (kind == 4'hD) || ((kind == 4'h8) && !ZF);

   assign wr_en   = load_en && ((state == S_IDLE) || (state == S_DONE));
   assign running = (state == S_RUN) || (state == S_STALL);
   assign done    = (state == S_DONE);

   always_comb begin
      state_n    = state;
      opcode_n   = opcode;
      pc_n       = pc;
      count_n    = fetch_count;
      kind_n     = kind;
      fetch      = 1'b0;
      restart    = 1'b0;
      fetch_addr = pc;

      case (state)
         S_IDLE: begin
            if (start) begin
               state_n    = S_RUN;
               fetch      = 1'b1;
               restart    = 1'b1;
               fetch_addr = 4'd0;
            end
         end
         S_RUN: begin
            if (halt || (opcode[7:4] == 4'hF)) begin
               state_n  = S_DONE;
               opcode_n = BUBBLE;
            end else if ((opcode[7:4] == 4'h8) || (opcode[7:4] == 4'h9) ||
                         (opcode[7:4] == 4'hD)) begin
               state_n  = S_STALL;
               opcode_n = BUBBLE;
               kind_n   = opcode[7:4];
            end else begin
               fetch = 1'b1;
            end
         end
         S_STALL: begin
            if (halt) begin
               state_n  = S_DONE;
               opcode_n = BUBBLE;
            end else begin
               state_n = S_RUN;
               fetch   = 1'b1;
               if (jump_taken) begin
                  fetch_addr = OpAddOut;
               end
            end
         end
         S_DONE: begin
            if (start && !halt) begin
               state_n    = S_RUN;
               fetch      = 1'b1;
               restart    = 1'b1;
               fetch_addr = 4'd0;
            end
         end
         default: begin
            state_n  = S_IDLE;
            opcode_n = BUBBLE;
         end
      endcase

      // Memory read sees the pre-edge contents, so a write landing on the
      // same edge as a start is not visible to that first fetch.
      if (fetch) begin
         opcode_n = mem[fetch_addr];
         pc_n     = fetch_addr + 4'd1;
         if (restart) begin
            count_n = 8'd1;
         end else if (fetch_count != 8'hFF) begin
            count_n = fetch_count + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         opcode      <= BUBBLE;
         pc          <= 4'd0;
         fetch_count <= 8'd0;
         kind        <= 4'd0;
      end else begin
         state       <= state_n;
         opcode      <= opcode_n;
         pc          <= pc_n;
         fetch_count <= count_n;
         kind        <= kind_n;
      end
   end

   // Program memory is deliberately outside reset so a program survives it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_en;
   logic [3:0] load_addr;
   logic [7:0] load_data;
   logic       start;
   logic       halt;
   logic       ZF;
   logic [3:0] OpAddOut;
   logic [7:0] opcode;
   logic [3:0] pc;
   logic       running;
   logic       done;
   logic [7:0] fetch_count;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   always #5 clk = ~clk;

   program_sequencer #(.BUBBLE(8'h00)) dut (
      .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .halt(halt), .ZF(ZF),
      .OpAddOut(OpAddOut), .opcode(opcode), .pc(pc), .running(running),
      .done(done), .fetch_count(fetch_count)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0 idle, 1 issuing, 2 waiting on a jump target, 3 finished.
   logic [7:0] m_mem [16];
   logic [7:0] m_op;
   int         m_pc;
   int         m_cnt;
   int         m_phase;
   int         m_kind;

   task automatic m_issue(input int addr);
      m_op  = m_mem[addr];
      m_pc  = (addr + 1) % 16;
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_op = 8'h00; m_pc = 0; m_cnt = 0; m_phase = 0; m_kind = 0;
      end else begin
         automatic bit writable = load_en && (m_phase == 0 || m_phase == 3);
         automatic int cls = int'(m_op[7:4]);
         if (m_phase == 0 || m_phase == 3) begin
            if (start && (m_phase == 0 || !halt)) begin
               m_cnt = 0;
               m_issue(0);
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            if (halt || cls == 15) begin
               m_phase = 3; m_op = 8'h00;
            end else if (cls == 8 || cls == 9 || cls == 13) begin
               m_phase = 2; m_kind = cls; m_op = 8'h00;
            end else begin
               m_issue(m_pc);
            end
         end else begin
            if (halt) begin
               m_phase = 3; m_op = 8'h00;
            end else begin
               if (m_kind != 8 || !ZF) m_issue(int'(OpAddOut));
               else m_issue(m_pc);
               m_phase = 1;
            end
         end
         if (writable) m_mem[load_addr] = load_data;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_opcode", opcode, m_op);
         check("cyc_pc", pc, m_pc);
         check("cyc_count", fetch_count, m_cnt);
         check("cyc_running", running, (m_phase == 1 || m_phase == 2));
         check("cyc_done", done, (m_phase == 3));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic load(input logic [3:0] a, input logic [7:0] d);
      load_en = 1'b1; load_addr = a; load_data = d;
      step();
      load_en = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_data = 8'h00;
      start = 1'b0; halt = 1'b0; ZF = 1'b0; OpAddOut = 4'd0;
      step(2);
      chk_en = 1'b1;
      check("rst_opcode", opcode, 8'h00);
      check("rst_pc", pc, 4'd0);
      check("rst_count", fetch_count, 8'd0);
      check("rst_running", running, 1'b0);
      check("rst_done", done, 1'b0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) load(4'(i), 8'h20 + 8'(i));
      check("idle_opcode", opcode, 8'h00);

      // Straight-line program ending in Fx
      load(4'd0, 8'h03); load(4'd1, 8'h12); load(4'd2, 8'hF0);
      pulse_start();
      check("seq_op0", opcode, 8'h03); check("seq_pc0", pc, 4'd1);
      step(); check("seq_op1", opcode, 8'h12);
      step(); check("seq_op2", opcode, 8'hF0);
      step();
      check("seq_bubble", opcode, 8'h00); check("seq_done", done, 1'b1);
      check("seq_count", fetch_count, 8'd3); check("seq_pc", pc, 4'd3);

      // Unconditional Dx jump
      load(4'd0, 8'hD5); load(4'd7, 8'h01); OpAddOut = 4'd7;
      pulse_start();
      check("jmp_op0", opcode, 8'hD5);
      step(); check("jmp_bubble", opcode, 8'h00); check("jmp_running", running, 1'b1);
      step(); check("jmp_target", opcode, 8'h01); check("jmp_pc", pc, 4'd8);
      check("jmp_count", fetch_count, 8'd2);
      halt = 1'b1; step(); check("jmp_halt_done", done, 1'b1);
      start = 1'b1; step(); start = 1'b0;
      check("start_halt_ignored", done, 1'b1); check("start_halt_count", fetch_count, 8'd2);
      halt = 1'b0;

      // 8x branch, not taken then taken
      load(4'd0, 8'h80); load(4'd1, 8'h04); ZF = 1'b1; OpAddOut = 4'd9;
      pulse_start();
      check("bnt_op0", opcode, 8'h80);
      step(); check("bnt_bubble", opcode, 8'h00);
      step(); check("bnt_next", opcode, 8'h04); check("bnt_pc", pc, 4'd2);
      halt = 1'b1; step(); halt = 1'b0;
      load(4'd9, 8'h2A); ZF = 1'b0;
      pulse_start(); check("bt_op0", opcode, 8'h80);
      step();
      step(); check("bt_target", opcode, 8'h2A); check("bt_pc", pc, 4'd10);
      halt = 1'b1; step(); halt = 1'b0;

      // halt sampled in STALL
      load(4'd0, 8'hD5); OpAddOut = 4'd7;
      pulse_start(); step();
      halt = 1'b1; step(); halt = 1'b0;
      check("stall_halt_done", done, 1'b1); check("stall_halt_op", opcode, 8'h00);
      check("stall_halt_count", fetch_count, 8'd1);

      // reset during STALL
      pulse_start(); step();
      reset = 1'b1; step(); reset = 1'b0;
      check("rst_stall_op", opcode, 8'h00); check("rst_stall_pc", pc, 4'd0);
      check("rst_stall_count", fetch_count, 8'd0); check("rst_stall_run", running, 1'b0);
      pulse_start();
      check("rst_restart_op", opcode, 8'hD5); check("rst_restart_count", fetch_count, 8'd1);
      halt = 1'b1; step(); halt = 1'b0;

      // write and start on the same edge
      load_en = 1'b1; load_addr = 4'd0; load_data = 8'h33; start = 1'b1;
      step(); load_en = 1'b0; start = 1'b0;
      check("wr_start_old", opcode, 8'hD5);
      halt = 1'b1; step(); halt = 1'b0;
      pulse_start(); check("wr_start_new", opcode, 8'h33);
      halt = 1'b1; step(); halt = 1'b0;

      // writes during RUN/STALL ignored, 9x jump, halt/start interplay
      load(4'd0, 8'h11); load(4'd1, 8'h95); load(4'd2, 8'h13); load(4'd3, 8'h14);
      OpAddOut = 4'd2;
      pulse_start(); check("run_op0", opcode, 8'h11);
      load_en = 1'b1; load_addr = 4'd0; load_data = 8'hEE;
      step(); check("run_op1", opcode, 8'h95);
      load_addr = 4'd2; load_data = 8'hFF;
      step(); check("run_bubble", opcode, 8'h00);
      load_en = 1'b0;
      step(); check("run_j9", opcode, 8'h13); check("run_j9_pc", pc, 4'd3);
      halt = 1'b1; step(); check("run_halt_done", done, 1'b1);
      start = 1'b1; step(); check("run_start_ignored", done, 1'b1);
      halt = 1'b0; step(); start = 1'b0;
      check("run_restart_op", opcode, 8'h11); check("run_restart_count", fetch_count, 8'd1);
      step(); step();
      step(); check("run_mem2_kept", opcode, 8'h13);
      halt = 1'b1; step(); halt = 1'b0;

      // pc wrap and fetch_count saturation
      for (int i = 0; i < 16; i++) load(4'(i), 8'h40 + 8'(i));
      pulse_start(); check("wrap_op0", opcode, 8'h40);
      step(15); check("wrap_op15", opcode, 8'h4F); check("wrap_pc", pc, 4'd0);
      step(); check("wrap_refetch", opcode, 8'h40); check("wrap_count", fetch_count, 8'd17);
      step(238); check("sat_255", fetch_count, 8'd255);
      step(20); check("sat_hold", fetch_count, 8'd255);
      halt = 1'b1; step(); halt = 1'b0;
      check("sat_done", done, 1'b1);

      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous active-high reset; one clock, no other clock domain.
REQ-003 SHALL have ports: load_en  in  1  write strobe for program memory.
REQ-004 SHALL have ports: load_addr  in  4  program memory write address.
REQ-005 SHALL have ports: load_data  in  8  program memory write data (one CPU opcode).
REQ-006 SHALL have ports: start  in  1  begin execution from address 0.
REQ-007 SHALL have ports: halt  in  1  CPU halt flag.
REQ-008 SHALL have ports: ZF  in  1  CPU zero flag.
REQ-009 SHALL have ports: OpAddOut  in  4  CPU jump-target output.
REQ-010 SHALL have ports: opcode  out  8  registered opcode driven to the CPU.
REQ-011 SHALL have ports: pc  out  4  address of the next opcode to fetch.
REQ-012 SHALL have ports: running  out  1  high in RUN or STALL.
REQ-013 SHALL have ports: done  out  1  high in DONE.
REQ-014 SHALL have ports: fetch_count  out  8  program opcodes issued since start, excluding bubbles.
REQ-015 SHALL define the parameter BUBBLE, default 8'h00, meaning the filler opcode issued on non-fetch cycles (ADD 0, leaves A unchanged).

Function
REQ-016 SHALL hold a 16 x 8 program memory, written only in IDLE or DONE when load_en=1: mem[load_addr] <= load_data; writes in RUN/STALL are ignored.
REQ-017 SHALL implement states IDLE, RUN, STALL, DONE.
REQ-018 In IDLE with start=1: state -> RUN; opcode <= mem[0]; pc <= 1; fetch_count <= 1.
REQ-019 Simultaneous load_en and start in IDLE: write and start both take effect, but the write is not visible to the same-cycle fetch.
REQ-020 In RUN, decode the currently presented opcode[7:4] at each edge, in the priority given by REQ-021 to REQ-024.
REQ-021 RUN, halt=1 or opcode[7:4]=4'hF: state -> DONE; opcode <= BUBBLE; pc holds.
REQ-022 RUN, opcode[7:4] in {4'h8, 4'h9, 4'hD}: state -> STALL; opcode <= BUBBLE; pc holds; the jump kind is latched.
REQ-023 RUN, otherwise: opcode <= mem[pc]; pc <= pc+1 (4-bit wrap, 15 -> 0); fetch_count increments.
REQ-024 STALL lasts one cycle; at its edge OpAddOut is valid and the jump is taken when the kind is 4'h9 or 4'hD, or when the kind is 4'h8 and ZF=0.
REQ-025 STALL, taken: opcode <= mem[OpAddOut]; pc <= OpAddOut+1 (wrap); state -> RUN.
REQ-026 STALL, not taken: opcode <= mem[pc]; pc <= pc+1; state -> RUN.
REQ-027 A STALL fetch SHALL increment fetch_count.
REQ-028 A halt=1 sampled in STALL SHALL take priority: state -> DONE; opcode <= BUBBLE.
REQ-029 fetch_count SHALL saturate at 255, with no wrap.
REQ-030 DONE, start=1 and halt=0: behaves as REQ-018, with fetch_count restarting at 1.
REQ-031 DONE, start=1 and halt=1: start is ignored.
REQ-032 opcode SHALL present BUBBLE in IDLE and DONE.
REQ-033 The latency from a fetch decision to the opcode change SHALL be one clock.
REQ-034 The bubble cost SHALL be exactly one per jump-class opcode, taken or not.

Reset
REQ-035 reset=1 at an edge SHALL force state=IDLE, opcode=BUBBLE, pc=0, fetch_count=0, running=0, done=0, and clear the latched jump kind, overriding every other input, including mid-RUN or mid-STALL.
REQ-036 Program memory contents SHALL be retained across reset and are undefined only after power-up.

Verification
REQ-037 Load mem[0..2] = 0x03, 0x12, 0xF0; pulse start -> opcode sequence 0x03, 0x12, 0xF0, then 0x00 with done=1, fetch_count=3, pc=3.
REQ-038 mem[0]=0xD5, mem[7]=0x01; drive OpAddOut=7 during STALL -> opcode 0xD5, 0x00, 0x01; pc=8; fetch_count=2.
REQ-039 mem[0]=0x80, mem[1]=0x04; ZF=1 in STALL -> branch not taken, opcode 0x80, 0x00, 0x04; with ZF=0 and OpAddOut=9 -> mem[9] fetched, pc=10.
REQ-040 Program of 16 opcodes with no jumps or halts -> pc wraps 15 -> 0 and mem[0] is re-fetched; fetch_count saturates at 255 after 255 fetches.
REQ-041 Assert reset during STALL -> next cycle state IDLE, opcode 0x00, pc 0, fetch_count 0; after start, memory is unchanged and mem[0] is re-issued.
REQ-042 Assert halt input mid-RUN -> done=1 next cycle; start with halt=1 is ignored; start with halt=0 restarts at mem[0]; load_en during RUN does not modify memory.
